// File: rtl/tictactoe_move_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tictactoe_move_arbiter
// Purpose  : Sequences every square selection into the TicTacToe game FSM.
//            Chooses between the human square buttons and an automatic O
//            player, debounces human presses and rejects illegal moves. It
//            then drives a one-hot cuadro pulse and waits for the board to
//            acknowledge the move.
// Ports    : clk_100MHz  - single clock
//            reset       - asynchronous active-high reset
//            btn_cuadro  - raw human square buttons (bit i = square i)
//            auto_en     - O is played by the auto player
//            auto_req    - auto player has a move pending
//            auto_idx    - auto player square index 0..8
//            x, o        - current board occupancy
//            turnoX      - 1 when it is X's turn
//            game_over   - 1 blocks all moves
//            cuadro      - one-hot move into the game FSM
//            auto_grant  - 1-cycle pulse when an auto move is acknowledged
//            reject      - 1-cycle pulse on an illegal move
//            timeout     - 1-cycle pulse when no acknowledge arrives
//            busy        - 1 outside IDLE
//            state       - encoded state for debug
// Revision : 1.0 - initial release
// ============================================================================
module tictactoe_move_arbiter #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 100,
    parameter int ACK_TIMEOUT     = 255,
    parameter int GAP_CYCLES      = 10
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [8:0] btn_cuadro,
    input  logic       auto_en,
    input  logic       auto_req,
    input  logic [3:0] auto_idx,
    input  logic [8:0] x,
    input  logic [8:0] o,
    input  logic       turnoX,
    input  logic       game_over,
    output logic [8:0] cuadro,
    output logic       auto_grant,
    output logic       reject,
    output logic       timeout,
    output logic       busy,
    output logic [2:0] state
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_DEBOUNCE = 3'd1;
    localparam logic [2:0] c_CHECK    = 3'd2;
    localparam logic [2:0] c_DRIVE    = 3'd3;
    localparam logic [2:0] c_WAIT_ACK = 3'd4;
    localparam logic [2:0] c_RELEASE  = 3'd5;

    // Terminal values of the shared 16-bit phase counter.
    localparam logic [15:0] c_DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] c_HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] c_ACK_LAST  = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] c_GAP_LAST  = 16'(GAP_CYCLES - 1);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [8:0]  r_move;
    logic        r_is_auto;
    logic [8:0]  r_cuadro;
    logic        r_grant;
    logic        r_reject;
    logic        r_timeout;
    logic        r_busy;

    logic [2:0]  w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [8:0]  w_move_nxt;
    logic        w_is_auto_nxt;
    logic [8:0]  w_cuadro_nxt;
    logic        w_grant_nxt;
    logic        w_reject_nxt;
    logic        w_timeout_nxt;

    logic        w_auto_sel;
    logic        w_human_sel;
    logic [8:0]  w_auto_onehot;
    logic        w_one_hot;
    logic        w_occupied;

    // Auto always wins over a simultaneous button press; the human is only
    // eligible on X's turn or when nobody automatic plays O.
    assign w_auto_sel    = auto_en & ~turnoX & auto_req;
    assign w_human_sel   = ~w_auto_sel & (btn_cuadro != 9'd0) & (turnoX | ~auto_en);
    assign w_auto_onehot = (auto_idx <= 4'd8) ? (9'd1 << auto_idx) : 9'd0;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign w_one_hot  = (r_move != 9'd0) && ((r_move & (r_move - 9'd1)) == 9'd0);
    // Doubles as the acknowledge test in WAIT_ACK.
    assign w_occupied = |(r_move & (x | o));

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= 16'd0;
            r_move    <= 9'd0;
            r_is_auto <= 1'b0;
            r_cuadro  <= 9'd0;
            r_grant   <= 1'b0;
            r_reject  <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_move    <= w_move_nxt;
            r_is_auto <= w_is_auto_nxt;
            r_cuadro  <= w_cuadro_nxt;
            r_grant   <= w_grant_nxt;
            r_reject  <= w_reject_nxt;
            r_timeout <= w_timeout_nxt;
            r_busy    <= (w_state_nxt != c_IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_move_nxt    = r_move;
        w_is_auto_nxt = r_is_auto;
        w_cuadro_nxt  = 9'd0;
        w_grant_nxt   = 1'b0;
        w_reject_nxt  = 1'b0;
        w_timeout_nxt = 1'b0;

        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = 16'd0;
                if (!game_over) begin
                    if (w_auto_sel) begin
                        w_move_nxt    = w_auto_onehot;
                        w_is_auto_nxt = 1'b1;
                        w_state_nxt   = c_CHECK;
                    end else if (w_human_sel) begin
                        w_move_nxt    = btn_cuadro;
                        w_is_auto_nxt = 1'b0;
                        w_state_nxt   = c_DEBOUNCE;
                    end
                end
            end

            c_DEBOUNCE: begin
                if (btn_cuadro != r_move) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_nxt = c_CHECK;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            c_CHECK: begin
                w_cnt_nxt = 16'd0;
                if (!w_one_hot || w_occupied || game_over) begin
                    w_reject_nxt = 1'b1;
                    // A rejected human press still has to be released.
                    w_state_nxt  = r_is_auto ? c_IDLE : c_RELEASE;
                end else begin
                    w_state_nxt  = c_DRIVE;
                    w_cuadro_nxt = r_move;
                end
            end

            c_DRIVE: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_state_nxt = c_WAIT_ACK;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt    = r_cnt + 16'd1;
                    w_cuadro_nxt = r_move;
                end
            end

            c_WAIT_ACK: begin
                if (w_occupied) begin
                    w_grant_nxt = r_is_auto;
                    w_state_nxt = c_RELEASE;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt == c_ACK_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = c_RELEASE;
                    w_cnt_nxt     = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            c_RELEASE: begin
                // Buttons only matter for a human move; any press restarts
                // the inter-move gap.
                if (!r_is_auto && (btn_cuadro != 9'd0)) begin
                    w_cnt_nxt = 16'd0;
                end else if (r_cnt == c_GAP_LAST) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    assign cuadro     = r_cuadro;
    assign auto_grant = r_grant;
    assign reject     = r_reject;
    assign timeout    = r_timeout;
    assign busy       = r_busy;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tictactoe_move_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tictactoe_move_arbiter
// Purpose  : Directed self-checking bench for tictactoe_move_arbiter with the
//            default timing parameters. Drives inputs and samples outputs on
//            the falling clock edge; the board (x/o) is modelled by the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tictactoe_move_arbiter;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic [8:0] btn_cuadro = 9'd0;
    logic       auto_en    = 1'b0;
    logic       auto_req   = 1'b0;
    logic [3:0] auto_idx   = 4'd0;
    logic [8:0] x          = 9'd0;
    logic [8:0] o          = 9'd0;
    logic       turnoX     = 1'b1;
    logic       game_over  = 1'b0;
    logic [8:0] cuadro;
    logic       auto_grant;
    logic       reject;
    logic       timeout;
    logic       busy;
    logic [2:0] state;

    tictactoe_move_arbiter dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .btn_cuadro (btn_cuadro),
        .auto_en    (auto_en),
        .auto_req   (auto_req),
        .auto_idx   (auto_idx),
        .x          (x),
        .o          (o),
        .turnoX     (turnoX),
        .game_over  (game_over),
        .cuadro     (cuadro),
        .auto_grant (auto_grant),
        .reject     (reject),
        .timeout    (timeout),
        .busy       (busy),
        .state      (state)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int n_checks = 0;
    int n_pass   = 0;

    // Running tallies of output activity, one count per high cycle.
    int n_cuad_cyc = 0;
    int n_rej      = 0;
    int n_to       = 0;
    int n_gr       = 0;
    always @(posedge clk_100MHz) begin
        if (cuadro != 9'd0) n_cuad_cyc++;
        if (reject)         n_rej++;
        if (timeout)        n_to++;
        if (auto_grant)     n_gr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cuadro(input int max, output int n);
        n = 0;
        while (cuadro == 9'd0 && n < max) begin
            @(negedge clk_100MHz);
            n++;
        end
    endtask

    task automatic count_hold(output int h);
        h = 0;
        while (cuadro != 9'd0 && h < 400) begin
            @(negedge clk_100MHz);
            h++;
        end
    endtask

    task automatic wait_reject(input int max, output int n);
        n = 0;
        while (!reject && n < max) begin
            @(negedge clk_100MHz);
            n++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk_100MHz);
            n++;
        end
    endtask

    initial begin
        int n, h, c0, r0, g0, t0;

        // ---- reset values ----
        repeat (3) @(negedge clk_100MHz);
        chk("rst_state",  state, 3'd0);
        chk("rst_cuadro", cuadro, 9'd0);
        chk("rst_busy",   busy, 1'b0);
        chk("rst_pulses", {auto_grant, reject, timeout}, 3'b000);
        reset = 1'b0;

        // ---- 1: human X move on square 0 ----
        auto_en = 1'b0; turnoX = 1'b1; btn_cuadro = 9'h001;
        t0 = n_to;
        wait_cuadro(1100, n);
        chk("t1_latency", n, 1002);
        chk("t1_cuadro", cuadro, 9'h001);
        count_hold(h);
        chk("t1_hold", h, 100);
        chk("t1_wait_ack", state, 3'd4);
        x = 9'h001;
        @(negedge clk_100MHz);
        chk("t1_release", state, 3'd5);
        repeat (800) @(negedge clk_100MHz);
        chk("t1_hold_btn", state, 3'd5);
        btn_cuadro = 9'h000;
        wait_idle(n);
        chk("t1_gap", n, 10);
        chk("t1_idle", {busy, state}, 4'd0);
        chk("t1_no_timeout", n_to - t0, 0);

        // ---- 2: bouncing press on square 3 ----
        c0 = n_cuad_cyc;
        for (int k = 0; k < 12; k++) begin
            btn_cuadro = (k % 2 == 0) ? 9'h008 : 9'h000;
            repeat (50) @(negedge clk_100MHz);
        end
        chk("t2_no_cuadro_bounce", n_cuad_cyc - c0, 0);
        chk("t2_idle_after_bounce", state, 3'd0);
        btn_cuadro = 9'h008;
        wait_cuadro(1100, n);
        chk("t2_latency", n, 1002);
        chk("t2_cuadro", cuadro, 9'h008);
        count_hold(h);
        x = 9'h009;
        btn_cuadro = 9'h000;
        wait_idle(n);
        chk("t2_idle", state, 3'd0);

        // ---- 3: occupied square, then multi-press ----
        c0 = n_cuad_cyc; r0 = n_rej;
        btn_cuadro = 9'h001;
        wait_reject(1100, n);
        chk("t3_occ_latency", n, 1002);
        chk("t3_occ_state", state, 3'd5);
        @(negedge clk_100MHz);
        chk("t3_occ_pulse_width", reject, 1'b0);
        btn_cuadro = 9'h000;
        wait_idle(n);
        btn_cuadro = 9'h003;
        wait_reject(1100, n);
        chk("t3_multi_latency", n, 1002);
        @(negedge clk_100MHz);
        btn_cuadro = 9'h000;
        wait_idle(n);
        chk("t3_reject_count", n_rej - r0, 2);
        chk("t3_no_cuadro", n_cuad_cyc - c0, 0);

        // ---- 4: auto O move on square 8, then out-of-range index ----
        auto_en = 1'b1; turnoX = 1'b0;
        g0 = n_gr;
        auto_idx = 4'd8; auto_req = 1'b1;
        wait_cuadro(10, n);
        chk("t4_latency", n, 2);
        chk("t4_cuadro", cuadro, 9'h100);
        count_hold(h);
        chk("t4_hold", h, 100);
        o = 9'h100;
        @(negedge clk_100MHz);
        chk("t4_grant", auto_grant, 1'b1);
        auto_req = 1'b0;
        @(negedge clk_100MHz);
        chk("t4_grant_width", auto_grant, 1'b0);
        wait_idle(n);
        chk("t4_grant_count", n_gr - g0, 1);
        c0 = n_cuad_cyc;
        auto_idx = 4'd9; auto_req = 1'b1;
        wait_reject(10, n);
        chk("t4_bad_idx_reject", n, 2);
        chk("t4_bad_idx_state", state, 3'd0);
        auto_req = 1'b0;
        @(negedge clk_100MHz);
        chk("t4_bad_idx_no_cuadro", n_cuad_cyc - c0, 0);

        // ---- 5: human ignored on auto's turn, then ack timeout ----
        c0 = n_cuad_cyc; r0 = n_rej;
        btn_cuadro = 9'h010;
        repeat (1200) @(negedge clk_100MHz);
        chk("t5_ignored_cuadro", n_cuad_cyc - c0, 0);
        chk("t5_ignored_reject", n_rej - r0, 0);
        chk("t5_ignored_busy", busy, 1'b0);
        btn_cuadro = 9'h000;
        g0 = n_gr;
        auto_idx = 4'd4; auto_req = 1'b1;
        wait_cuadro(10, n);
        chk("t5_cuadro", cuadro, 9'h010);
        count_hold(h);
        n = 0;
        while (!timeout && n < 400) begin
            @(negedge clk_100MHz);
            n++;
        end
        chk("t5_timeout_delay", n, 255);
        chk("t5_no_grant", n_gr - g0, 0);
        auto_req = 1'b0;
        wait_idle(n);

        // ---- 6: simultaneous request and press, reset mid-DRIVE ----
        btn_cuadro = 9'h001; auto_idx = 4'd4; auto_req = 1'b1;
        wait_cuadro(10, n);
        chk("t6_auto_wins", cuadro, 9'h010);
        repeat (5) @(negedge clk_100MHz);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_cuadro", cuadro, 9'd0);
        chk("t6_async_state", state, 3'd0);
        @(negedge clk_100MHz);
        reset = 1'b0; auto_req = 1'b0; btn_cuadro = 9'h000;

        // ---- game over blocks everything ----
        game_over = 1'b1;
        c0 = n_cuad_cyc; r0 = n_rej;
        auto_idx = 4'd2; auto_req = 1'b1;
        repeat (50) @(negedge clk_100MHz);
        chk("t6_go_auto_busy", busy, 1'b0);
        auto_req = 1'b0; auto_en = 1'b0; turnoX = 1'b1;
        btn_cuadro = 9'h002;
        repeat (1100) @(negedge clk_100MHz);
        chk("t6_go_state", state, 3'd0);
        chk("t6_go_no_cuadro", n_cuad_cyc - c0, 0);
        chk("t6_go_no_reject", n_rej - r0, 0);
        btn_cuadro = 9'h000;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
